// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory target with wait states, byte/half/word access and load extension.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  write_ctrl,
  input  logic [2:0]  read_ctrl,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    wc_q;
  logic [2:0]    rc_q;
  logic          resp_valid_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_word;
  logic [31:0]   word_d;
  logic [31:0]   wr_lanes;
  logic [3:0]    be;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          half_acc;
  logic          word_acc;
  logic          bad;
  logic [31:0]   ld_data;
  logic          unused_addr;
  // Upper address bits alias onto the storage and are deliberately dropped.
  assign unused_addr = ^addr[31:AW+2];
  always_comb begin
    rd_word  = mem[addr_q[AW+1:2]];
    be       = (wc_q == 2'd3) ? 4'hF : (wc_q == 2'd2) ? (addr_q[1] ? 4'hC : 4'h3) :
               (wc_q == 2'd1) ? (4'b0001 << addr_q[1:0]) : 4'h0;
    wr_lanes = (wc_q == 2'd3) ? wdata_q : (wc_q == 2'd2) ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    word_d   = rd_word;
    for (int i = 0; i < 4; i++) word_d[8*i +: 8] = be[i] ? wr_lanes[8*i +: 8] : rd_word[8*i +: 8];
    byte_sel = 8'(rd_word >> {addr_q[1:0], 3'b000});
    half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    half_acc = (rc_q == 3'd2) || (rc_q == 3'd5) || (wc_q == 2'd2);
    word_acc = (rc_q == 3'd3) || (wc_q == 2'd3);
    bad      = (rc_q[2:1] == 2'b11) || ((rc_q != 3'd0) && (wc_q != 2'd0)) ||
               (half_acc && addr_q[0]) || (word_acc && (addr_q[1:0] != 2'b00));
    ld_data  = bad ? 32'h0 :
               (rc_q == 3'd1) ? {{24{byte_sel[7]}}, byte_sel} :
               (rc_q == 3'd2) ? {{16{half_sel[15]}}, half_sel} :
               (rc_q == 3'd3) ? rd_word :
               (rc_q == 3'd4) ? {24'h0, byte_sel} :
               (rc_q == 3'd5) ? {16'h0, half_sel} : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (_reset && state_q == S_ACCESS && !bad && wc_q != 2'd0) mem[addr_q[AW+1:2]] <= word_d;
  end
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wc_q         <= '0;
      rc_q         <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q  <= addr[AW+1:0];
          wdata_q <= wdata;
          wc_q    <= write_ctrl;
          rc_q    <= read_ctrl;
          cnt_q   <= CW'(WAIT_STATES);
          state_q <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
        S_WAIT: begin
          cnt_q   <= cnt_q - 1'b1;
          state_q <= (cnt_q == CW'(1)) ? S_ACCESS : S_WAIT;
        end
        S_ACCESS: begin
          rdata_q      <= ld_data;
          err_q        <= bad;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table plus scoreboard queue checking dmem_responder responses and timing.
module tb_dmem_responder;
  localparam int WS = 2;
  logic        clk = 1'b0;
  logic        _reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  write_ctrl = '0;
  logic [2:0]  read_ctrl = '0;
  logic        req_ready, resp_valid, err, busy;
  logic [31:0] rdata;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [1:0]  wc;
    logic [2:0]  rc;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e;
  } vec_t;
  typedef struct {
    logic [31:0] rd;
    logic        e;
  } exp_t;
  exp_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS)) dut (
    .clk(clk), ._reset(_reset), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .wdata(wdata), .write_ctrl(write_ctrl), .read_ctrl(read_ctrl),
    .resp_valid(resp_valid), .rdata(rdata), .err(err), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] wc, input logic [2:0] rc, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic e);
    vec_t v;
    v.wc = wc; v.rc = rc; v.a = a; v.wd = wd; v.rd = rd; v.e = e;
    return v;
  endfunction

  always @(negedge clk) begin : mon
    exp_t x;
    if (_reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_resp: got rdata %h err %b with nothing outstanding", rdata, err);
      end else begin
        x = exp_q.pop_front();
        check("rdata", rdata, x.rd);
        check("err", {31'b0, err}, {31'b0, x.e});
      end
    end
  end

  task automatic drive(input vec_t v);
    int n;
    @(posedge clk); #1;
    check("ready", {31'b0, req_ready}, 32'd1);
    addr = v.a; wdata = v.wd; write_ctrl = v.wc; read_ctrl = v.rc; req_valid = 1'b1;
    exp_q.push_back('{v.rd, v.e});
    @(posedge clk); #1;
    req_valid = 1'b0;
    addr = $urandom; wdata = $urandom; write_ctrl = 2'($urandom); read_ctrl = 3'($urandom);
    n = 1;
    while (!resp_valid && n < 20) begin
      check("busy", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, WS + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int resp_n, rdy_n, bad_n;
    tbl.push_back(mk(2'd3, 3'd0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0));
    tbl.push_back(mk(2'd0, 3'd3, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(2'd1, 3'd0, 32'h11,  32'h000000A5, 32'h0,        1'b0));
    tbl.push_back(mk(2'd0, 3'd3, 32'h10,  32'h0,        32'hDEADA5EF, 1'b0));
    tbl.push_back(mk(2'd0, 3'd1, 32'h11,  32'h0,        32'hFFFFFFA5, 1'b0));
    tbl.push_back(mk(2'd0, 3'd4, 32'h11,  32'h0,        32'h000000A5, 1'b0));
    tbl.push_back(mk(2'd2, 3'd0, 32'h12,  32'h00008001, 32'h0,        1'b0));
    tbl.push_back(mk(2'd0, 3'd2, 32'h12,  32'h0,        32'hFFFF8001, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h12,  32'h0,        32'h00008001, 1'b0));
    tbl.push_back(mk(2'd0, 3'd2, 32'h13,  32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(2'd2, 3'd0, 32'h13,  32'hFFFFFFFF, 32'h0,        1'b1));
    tbl.push_back(mk(2'd3, 3'd0, 32'h11,  32'hFFFFFFFF, 32'h0,        1'b1));
    tbl.push_back(mk(2'd0, 3'd3, 32'h12,  32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(2'd0, 3'd6, 32'h10,  32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(2'd0, 3'd7, 32'h10,  32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(2'd1, 3'd1, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1));
    tbl.push_back(mk(2'd0, 3'd3, 32'h10,  32'h0,        32'h8001A5EF, 1'b0));
    tbl.push_back(mk(2'd0, 3'd0, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b0));
    tbl.push_back(mk(2'd3, 3'd0, 32'h400, 32'h12345678, 32'h0,        1'b0));
    tbl.push_back(mk(2'd0, 3'd3, 32'h0,   32'h0,        32'h12345678, 1'b0));
    tbl.push_back(mk(2'd0, 3'd1, 32'h403, 32'h0,        32'h00000012, 1'b0));
    tbl.push_back(mk(2'd0, 3'd1, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0));
    tbl.push_back(mk(2'd0, 3'd2, 32'h10,  32'h0,        32'hFFFFA5EF, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h10,  32'h0,        32'h0000A5EF, 1'b0));
    tbl.push_back(mk(2'd0, 3'd4, 32'h13,  32'h0,        32'h00000080, 1'b0));
    tbl.push_back(mk(2'd0, 3'd1, 32'h12,  32'h0,        32'h00000001, 1'b0));
    tbl.push_back(mk(2'd1, 3'd0, 32'h13,  32'h12345677, 32'h0,        1'b0));
    tbl.push_back(mk(2'd0, 3'd3, 32'h10,  32'h0,        32'h7701A5EF, 1'b0));
    tbl.push_back(mk(2'd3, 3'd0, 32'h20,  32'h0,        32'h0,        1'b0));

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_resp", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'b0, err}, 32'd0);
    _reset = 1'b1;

    foreach (tbl[i]) drive(tbl[i]);

    // Hold req_valid: second request must only be taken once the FSM is idle again.
    @(posedge clk); #1;
    check("hold_ready", {31'b0, req_ready}, 32'd1);
    addr = 32'h10; wdata = 32'h0; write_ctrl = 2'd0; read_ctrl = 3'd3; req_valid = 1'b1;
    exp_q.push_back('{32'h7701A5EF, 1'b0});
    exp_q.push_back('{32'h00000077, 1'b0});
    resp_n = 0; rdy_n = 0; bad_n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin addr = 32'h13; read_ctrl = 3'd4; end
      resp_n += int'(resp_valid);
      rdy_n  += int'(req_ready);
      if (busy === req_ready) bad_n++;
    end
    req_valid = 1'b0;
    check("hold_resp_count", resp_n, 32'd2);
    check("hold_ready_count", rdy_n, 32'd2);
    check("hold_busy_vs_ready", bad_n, 32'd0);

    // Abort a store during WAIT with an asynchronous reset.
    @(posedge clk); #1;
    addr = 32'h20; wdata = 32'hCAFEF00D; write_ctrl = 2'd3; read_ctrl = 3'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    @(negedge clk);
    _reset = 1'b0;
    #1;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_resp", {31'b0, resp_valid}, 32'd0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_err", {31'b0, err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    _reset = 1'b1;
    drive(mk(2'd0, 3'd3, 32'h20, 32'h0, 32'h0, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
